// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, register-op encodings and queue entry layout
package wb_arbiter_pkg;

    localparam int DATA_BUS     = 16;
    localparam int REG_ADDR_BUS = 3;
    localparam int REG_OP_BUS   = 3;
    localparam int FIFO_DEPTH   = 4;
    localparam int ENTRY_W      = REG_OP_BUS + REG_ADDR_BUS + DATA_BUS;

    typedef enum logic [REG_OP_BUS-1:0] {
        REG_OP_NOP = 3'd0,
        REG_OP_REG = 3'd1,
        REG_OP_T   = 3'd2,
        REG_OP_SP  = 3'd3,
        REG_OP_IH  = 3'd4,
        REG_OP_RA  = 3'd5
    } reg_op_e;

    typedef struct packed {
        logic [REG_OP_BUS-1:0]   op;
        logic [REG_ADDR_BUS-1:0] addr;
        logic [DATA_BUS-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - 4-entry dual-push single-pop FIFO exposing every slot
module wb_fifo
    import wb_arbiter_pkg::*;
(
    input  logic                          clk_50MHz,
    input  logic                          rst,
    input  logic                          push_a,
    input  logic [ENTRY_W-1:0]            data_a,
    input  logic                          push_b,
    input  logic [ENTRY_W-1:0]            data_b,
    input  logic                          pop,
    output logic [ENTRY_W-1:0]            head,
    output logic [FIFO_DEPTH*ENTRY_W-1:0] entries,
    output logic [FIFO_DEPTH-1:0]         entry_valid,
    output logic [2:0]                    level
);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]         rd_ptr;
    logic [1:0]         wr_ptr;
    logic [1:0]         wr_next;
    logic [2:0]         level_q;
    logic               pop_ok;

    assign wr_next = wr_ptr + 2'd1;
    assign pop_ok  = pop && (level_q != 3'd0);
    assign head    = mem_q[rd_ptr];
    assign level   = level_q;

    // push_a is the older request, so it always lands in the lower slot
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr  <= 2'd0;
            wr_ptr  <= 2'd0;
            level_q <= 3'd0;
        end else begin
            if (push_a) mem_q[wr_ptr] <= data_a;
            if (push_b) mem_q[push_a ? wr_next : wr_ptr] <= data_b;
            wr_ptr  <= wr_ptr + 2'(push_a) + 2'(push_b);
            if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
            level_q <= level_q + 3'(push_a) + 3'(push_b) - 3'(pop_ok);
        end
    end

    always_comb begin
        entries     = '0;
        entry_valid = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic [1:0] offset;
            offset = 2'(i) - rd_ptr;
            entries[i*ENTRY_W +: ENTRY_W] = mem_q[i];
            entry_valid[i] = ({1'b0, offset} < level_q);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and load write-backs into one register-file write port
module wb_arbiter
    import wb_arbiter_pkg::*;
(
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [2:0]  alu_op,
    input  logic [2:0]  alu_addr,
    input  logic [15:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [2:0]  mem_op,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] mem_data,
    output logic [2:0]  reg_op,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    input  logic [2:0]  A_addr,
    input  logic [2:0]  B_addr,
    output logic        A_busy,
    output logic        B_busy,
    output logic        T_busy,
    output logic        SP_busy,
    output logic        IH_busy,
    output logic        RA_busy,
    output logic [2:0]  level
);

    logic                          alu_acc;
    logic                          mem_acc;
    logic                          pop;
    logic [ENTRY_W-1:0]            head;
    logic [FIFO_DEPTH*ENTRY_W-1:0] entries;
    logic [FIFO_DEPTH-1:0]         entry_valid;

    // Two free slots guarantee both sources can push together without overflow
    assign alu_ready = (level <= 3'd2);
    assign mem_ready = (level <= 3'd2);
    assign alu_acc   = alu_valid && alu_ready && (alu_op != REG_OP_NOP);
    assign mem_acc   = mem_valid && mem_ready && (mem_op != REG_OP_NOP);
    assign pop       = (level != 3'd0);

    wb_fifo u_fifo (
        .clk_50MHz   (clk_50MHz),
        .rst         (rst),
        .push_a      (mem_acc),
        .data_a      ({mem_op, mem_addr, mem_data}),
        .push_b      (alu_acc),
        .data_b      ({alu_op, alu_addr, alu_data}),
        .pop         (pop),
        .head        (head),
        .entries     (entries),
        .entry_valid (entry_valid),
        .level       (level)
    );

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            reg_op  <= REG_OP_NOP;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (pop) begin
            {reg_op, wb_addr, wb_data} <= head;
        end else begin
            reg_op  <= REG_OP_NOP;
            wb_addr <= '0;
            wb_data <= '0;
        end
    end

    // The output stage is committed before the next read, so only queued entries count
    always_comb begin
        wb_entry_t e;
        A_busy  = 1'b0;
        B_busy  = 1'b0;
        T_busy  = 1'b0;
        SP_busy = 1'b0;
        IH_busy = 1'b0;
        RA_busy = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            e = entries[i*ENTRY_W +: ENTRY_W];
            if (entry_valid[i]) begin
                if (e.op == REG_OP_REG && e.addr == A_addr) A_busy = 1'b1;
                if (e.op == REG_OP_REG && e.addr == B_addr) B_busy = 1'b1;
                if (e.op == REG_OP_T)  T_busy  = 1'b1;
                if (e.op == REG_OP_SP) SP_busy = 1'b1;
                if (e.op == REG_OP_IH) IH_busy = 1'b1;
                if (e.op == REG_OP_RA) RA_busy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk_50MHz = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [2:0]  alu_op = '0, alu_addr = '0, mem_op = '0, mem_addr = '0;
    logic [15:0] alu_data = '0, mem_data = '0;
    logic [2:0]  reg_op, wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  A_addr = '0, B_addr = '0;
    logic        A_busy, B_busy, T_busy, SP_busy, IH_busy, RA_busy;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;
    int model_level = 0;
    logic [21:0] exp_q [$];

    always #10 clk_50MHz = ~clk_50MHz;

    wb_arbiter dut (
        .clk_50MHz (clk_50MHz), .rst (rst),
        .alu_valid (alu_valid), .alu_ready (alu_ready),
        .alu_op (alu_op), .alu_addr (alu_addr), .alu_data (alu_data),
        .mem_valid (mem_valid), .mem_ready (mem_ready),
        .mem_op (mem_op), .mem_addr (mem_addr), .mem_data (mem_data),
        .reg_op (reg_op), .wb_addr (wb_addr), .wb_data (wb_data),
        .A_addr (A_addr), .B_addr (B_addr),
        .A_busy (A_busy), .B_busy (B_busy), .T_busy (T_busy),
        .SP_busy (SP_busy), .IH_busy (IH_busy), .RA_busy (RA_busy),
        .level (level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every non-NOP write on the port must match the scoreboard head
    always @(negedge clk_50MHz) begin
        if (rst && reg_op != 3'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got 0x%0h expected none", {reg_op, wb_addr, wb_data});
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                if ({reg_op, wb_addr, wb_data} !== e) begin
                    errors++;
                    $display("FAIL sb_order: got 0x%0h expected 0x%0h", {reg_op, wb_addr, wb_data}, e);
                end
            end
        end
    end

    task automatic cycle();
        int pushes;
        pushes = 0;
        check("alu_ready", {31'd0, alu_ready}, {31'd0, model_level <= 2});
        check("mem_ready", {31'd0, mem_ready}, {31'd0, model_level <= 2});
        if (model_level <= 2) begin
            if (mem_valid && mem_op != 3'd0) begin exp_q.push_back({mem_op, mem_addr, mem_data}); pushes++; end
            if (alu_valid && alu_op != 3'd0) begin exp_q.push_back({alu_op, alu_addr, alu_data}); pushes++; end
        end
        @(posedge clk_50MHz); #1;
        model_level = model_level + pushes - ((model_level > 0) ? 1 : 0);
        check("level", {29'd0, level}, model_level);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 8 && model_level > 0; i++) cycle();
        cycle();
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        #25;
        check("rst_reg_op", {29'd0, reg_op}, 0);
        check("rst_level", {29'd0, level}, 0);
        check("rst_ready", {30'd0, alu_ready, mem_ready}, 3);
        check("rst_busy", {26'd0, A_busy, B_busy, T_busy, SP_busy, IH_busy, RA_busy}, 0);
        @(negedge clk_50MHz); #3 rst = 1'b1;
        @(posedge clk_50MHz); #1;

        // Single push with A hazard
        A_addr = 3'd3; B_addr = 3'd5;
        alu_valid = 1'b1; alu_op = 3'd1; alu_addr = 3'd3; alu_data = 16'h1234;
        cycle(); idle();
        check("single_A_busy", {31'd0, A_busy}, 1);
        check("single_B_busy", {31'd0, B_busy}, 0);
        check("single_no_bypass", {29'd0, reg_op}, 0);
        cycle();
        check("single_A_busy_clr", {31'd0, A_busy}, 0);
        check("single_out", {10'd0, reg_op, wb_addr, wb_data}, {10'd0, 3'd1, 3'd3, 16'h1234});
        cycle();
        check("single_out_nop", {29'd0, reg_op}, 0);

        // Dual push: load first
        mem_valid = 1'b1; mem_op = 3'd3; mem_addr = 3'd0; mem_data = 16'h00FF;
        alu_valid = 1'b1; alu_op = 3'd1; alu_addr = 3'd1; alu_data = 16'hBEEF;
        cycle(); idle();
        check("dual_SP_busy", {31'd0, SP_busy}, 1);
        cycle();
        check("dual_first", {10'd0, reg_op, wb_addr, wb_data}, {10'd0, 3'd3, 3'd0, 16'h00FF});
        cycle();
        check("dual_second", {10'd0, reg_op, wb_addr, wb_data}, {10'd0, 3'd1, 3'd1, 16'hBEEF});
        drain();

        // T then IH special hazards
        alu_valid = 1'b1; alu_op = 3'd2; alu_addr = 3'd0; alu_data = 16'h0A0A;
        cycle();
        check("t_busy_q", {30'd0, T_busy, IH_busy}, 2'b10);
        alu_op = 3'd4; alu_data = 16'h0B0B;
        cycle(); idle();
        check("t_at_out", {30'd0, T_busy, IH_busy}, 2'b01);
        check("t_out_op", {29'd0, reg_op}, 2);
        cycle();
        check("ih_at_out", {30'd0, T_busy, IH_busy}, 2'b00);
        check("ih_out_op", {29'd0, reg_op}, 4);
        drain();

        // NOP filter
        alu_valid = 1'b1; alu_op = 3'd0; alu_addr = 3'd2; alu_data = 16'hDEAD;
        cycle(); idle();
        check("nop_level", {29'd0, level}, 0);
        cycle();
        check("nop_reg_op", {29'd0, reg_op}, 0);

        // Back-pressure: 100 accepted pushes under saturated valids
        begin
            int accepted, budget;
            accepted = 0; budget = 0;
            while (accepted < 100 && budget < 400) begin
                alu_valid = 1'b1; mem_valid = 1'b1;
                alu_op = 3'($urandom_range(1, 5)); alu_addr = 3'($urandom);
                alu_data = 16'($urandom);
                mem_op = 3'($urandom_range(1, 5)); mem_addr = 3'($urandom);
                mem_data = 16'($urandom);
                if (model_level <= 2) accepted += 2;
                cycle();
                check("bp_level_max", {31'd0, level <= 3'd3}, 1);
                budget++;
            end
            check("bp_budget", {31'd0, budget < 400}, 1);
        end
        drain();

        // Reset mid-operation at level 3
        mem_valid = 1'b1; mem_op = 3'd1; mem_addr = 3'd2; mem_data = 16'h1111;
        alu_valid = 1'b1; alu_op = 3'd5; alu_addr = 3'd0; alu_data = 16'h2222;
        cycle();
        mem_data = 16'h3333; alu_data = 16'h4444;
        cycle(); idle();
        check("pre_rst_level", {29'd0, level}, 3);
        A_addr = 3'd2;
        #5 rst = 1'b0;
        #1;
        exp_q.delete(); model_level = 0;
        check("mid_rst_reg_op", {29'd0, reg_op}, 0);
        check("mid_rst_level", {29'd0, level}, 0);
        check("mid_rst_ready", {30'd0, alu_ready, mem_ready}, 3);
        check("mid_rst_busy", {26'd0, A_busy, B_busy, T_busy, SP_busy, IH_busy, RA_busy}, 0);
        @(negedge clk_50MHz); #3 rst = 1'b1;
        @(posedge clk_50MHz); #1;
        cycle();
        check("post_rst_nop", {29'd0, reg_op}, 0);
        alu_valid = 1'b1; alu_op = 3'd1; alu_addr = 3'd6; alu_data = 16'h5A5A;
        cycle(); idle();
        check("post_rst_no_bypass", {29'd0, reg_op}, 0);
        cycle();
        check("post_rst_out", {10'd0, reg_op, wb_addr, wb_data}, {10'd0, 3'd1, 3'd6, 16'h5A5A});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
